// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encodings and seven-segment table for the sequential ALU controller.
// SEQ_ALU_MULT_EN decides whether OP_MUL counts as a supported opcode.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_MAX  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EXEC    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off; entry 0 is the rightmost element.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic op_supported(input logic [2:0] op);
`ifdef SEQ_ALU_MULT_EN
        return op != OP_RSVD;
`else
        return (op != OP_RSVD) && (op != OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// One hex digit to an active-low seven-segment pattern with the decimal point off.
module hex_to_seg7
    import seq_alu_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 16; i++) begin
            if (hex == 4'(i)) seg = SEG_TABLE[i];
        end
    end

endmodule

// File: rtl/seq_alu_ctrl.sv
// Operand collector, multi-cycle accumulator ALU and hex display driver.
// Build option SEQ_ALU_MULT_EN adds the shift-add multiplier for ms=101.
//
// state      | meaning
// ST_COLLECT | latching operands on each button press
// ST_EXEC    | folding operands 1..N_OPND-1 into the accumulator
// ST_DONE    | result and flags held until the next press
module seq_alu_ctrl
    import seq_alu_pkg::*;
#(
    parameter int DIN_W  = 4,
    parameter int N_OPND = 2,
    parameter int OUT_W  = 8,
    localparam int IDX_W = $clog2(N_OPND + 1),
    localparam int N_DIG = OUT_W / 4
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               next_n,
    input  logic [2:0]         ms,
    input  logic [DIN_W-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               err,
    output logic [IDX_W-1:0]   opnd_idx,
    output logic [OUT_W-1:0]   result,
    output logic [8*N_DIG-1:0] seg
);

    localparam int MUL_CYC = (N_OPND - 1) * DIN_W;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);

    state_t             state, state_nxt;
    logic               sync1, sync2, sync3, press;
    logic [DIN_W-1:0]   opnd [N_OPND];
    logic [IDX_W-1:0]   opnd_idx_q, op_ptr;
    logic [2:0]         op_q;
    logic [OUT_W-1:0]   acc, acc_nxt, opnd_ext;
    logic [OUT_W:0]     wide;
    logic               ovf_q, err_q, ovf_step;
    logic [CNT_W-1:0]   step_cnt;
    logic [DIN_W-1:0]   cur_opnd;
    logic               launch, launch_ok;

`ifdef SEQ_ALU_MULT_EN
    localparam int BIT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
    localparam int P_W   = OUT_W + DIN_W;
    logic [BIT_W-1:0] bit_idx;
    logic [P_W-1:0]   prod, prod_nxt;
    logic             mul_last;
`endif

    // Button path: two synchronizer flops, one history flop, registered fall detect.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
            press <= 1'b0;
        end else begin
            sync1 <= next_n;
            sync2 <= sync1;
            sync3 <= sync2;
            press <= sync3 & ~sync2;
        end
    end

    assign launch    = (state == ST_COLLECT) && press && (opnd_idx_q == IDX_W'(N_OPND - 1));
    assign launch_ok = op_supported(ms);

    always_comb begin
        cur_opnd = '0;
        for (int i = 0; i < N_OPND; i++) begin
            if (op_ptr == IDX_W'(i)) cur_opnd = opnd[i];
        end
    end

    assign opnd_ext = OUT_W'(cur_opnd);

`ifdef SEQ_ALU_MULT_EN
    assign mul_last = (bit_idx == BIT_W'(DIN_W - 1));
    assign prod_nxt = ((bit_idx == '0) ? P_W'(0) : prod)
                    + (cur_opnd[bit_idx] ? (P_W'(acc) << bit_idx) : P_W'(0));
`endif

    always_comb begin
        wide     = '0;
        acc_nxt  = acc;
        ovf_step = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide     = {1'b0, acc} + {1'b0, opnd_ext};
                acc_nxt  = wide[OUT_W-1:0];
                ovf_step = wide[OUT_W];
            end
            OP_SUB: begin
                wide     = {1'b0, acc} - {1'b0, opnd_ext};
                acc_nxt  = wide[OUT_W-1:0];
                ovf_step = wide[OUT_W];
            end
            OP_AND: acc_nxt = acc & opnd_ext;
            OP_OR:  acc_nxt = acc | opnd_ext;
            OP_XOR: acc_nxt = acc ^ opnd_ext;
            OP_MAX: acc_nxt = (acc > opnd_ext) ? acc : opnd_ext;
`ifdef SEQ_ALU_MULT_EN
            OP_MUL: begin
                acc_nxt  = prod_nxt[OUT_W-1:0];
                ovf_step = |prod_nxt[P_W-1:OUT_W];
            end
`endif
            default: acc_nxt = acc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (launch) state_nxt = launch_ok ? ST_EXEC : ST_DONE;
            ST_EXEC:    if (step_cnt == '0) state_nxt = ST_DONE;
            ST_DONE:    if (press) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= ST_COLLECT;
            for (int i = 0; i < N_OPND; i++) opnd[i] <= '0;
            opnd_idx_q <= '0;
            op_ptr     <= '0;
            op_q       <= OP_ADD;
            acc        <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            step_cnt   <= '0;
`ifdef SEQ_ALU_MULT_EN
            bit_idx    <= '0;
            prod       <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_COLLECT: begin
                    if (press) begin
                        for (int i = 0; i < N_OPND; i++) begin
                            if (opnd_idx_q == IDX_W'(i)) opnd[i] <= din;
                        end
                        opnd_idx_q <= opnd_idx_q + IDX_W'(1);
                    end
                    if (launch) begin
                        op_q   <= ms;
                        ovf_q  <= 1'b0;
                        op_ptr <= IDX_W'(1);
                        err_q  <= ~launch_ok;
                        acc    <= launch_ok ? OUT_W'(opnd[0]) : '0;
                        step_cnt <= CNT_W'(N_OPND - 2);
`ifdef SEQ_ALU_MULT_EN
                        bit_idx <= '0;
                        if (ms == OP_MUL) step_cnt <= CNT_W'(MUL_CYC - 1);
`endif
                    end
                end
                ST_EXEC: begin
                    if (step_cnt != '0) step_cnt <= step_cnt - CNT_W'(1);
`ifdef SEQ_ALU_MULT_EN
                    if (op_q == OP_MUL) begin
                        prod    <= prod_nxt;
                        bit_idx <= mul_last ? '0 : bit_idx + BIT_W'(1);
                        if (mul_last) begin
                            acc    <= acc_nxt;
                            ovf_q  <= ovf_q | ovf_step;
                            op_ptr <= op_ptr + IDX_W'(1);
                        end
                    end else
`endif
                    begin
                        acc    <= acc_nxt;
                        ovf_q  <= ovf_q | ovf_step;
                        op_ptr <= op_ptr + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (press) begin
                        opnd_idx_q <= '0;
                        err_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == ST_EXEC);
    assign done     = (state == ST_DONE);
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign opnd_idx = opnd_idx_q;
    assign result   = acc;

    for (genvar d = 0; d < N_DIG; d++) begin : g_dig
        hex_to_seg7 u_seg (
            .hex (acc[4*d +: 4]),
            .seg (seg[8*d +: 8])
        );
    end

endmodule

// File: tb/tb_seq_alu_ctrl.sv
// Directed bench for seq_alu_ctrl with DIN_W=4, N_OPND=2, OUT_W=8; follows SEQ_ALU_MULT_EN.
module tb_seq_alu_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic        next_n;
    logic [2:0]  ms;
    logic [3:0]  din;
    logic        busy, done, ovf, err;
    logic [1:0]  opnd_idx;
    logic [7:0]  result;
    logic [15:0] seg;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    seq_alu_ctrl #(.DIN_W(4), .N_OPND(2), .OUT_W(8)) dut (
        .clk(clk), .clear(clear), .next_n(next_n), .ms(ms), .din(din),
        .busy(busy), .done(done), .ovf(ovf), .err(err),
        .opnd_idx(opnd_idx), .result(result), .seg(seg)
    );

    always #2 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1) busy_cnt = busy_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        din = v;
        next_n = 1'b0;
        repeat (5) @(negedge clk);
        next_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        clear = 1'b1; next_n = 1'b1; din = 4'h0; ms = 3'b000;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, ovf, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, ovf, err}); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result); end
        checks++; if (seg !== 16'hC0C0) begin errors++; $display("FAIL reset_seg got %h exp c0c0", seg); end
        clear = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (opnd_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", opnd_idx); end
    endtask

    task automatic test_add();
        bit ok;
        ms = 3'b000; busy_cnt = 0;
        press(4'h2);
        checks++; if (opnd_idx !== 2'd1) begin errors++; $display("FAIL add_idx1 got %0d exp 1", opnd_idx); end
        press(4'h3);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", done); end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL add_busy got %0d exp 1", busy_cnt); end
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL add_result got %h exp 05", result); end
        checks++; if (seg !== 16'hC092) begin errors++; $display("FAIL add_seg got %h exp c092", seg); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got %b exp 0", ovf); end
        press(4'h0);
    endtask

    task automatic test_sub();
        bit ok;
        ms = 3'b001; busy_cnt = 0;
        press(4'h3);
        press(4'h4);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sub_done got %b exp 1", done); end
        checks++; if (result !== 8'hFF) begin errors++; $display("FAIL sub_result got %h exp ff", result); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf got %b exp 1", ovf); end
        checks++; if (seg !== 16'h8E8E) begin errors++; $display("FAIL sub_seg got %h exp 8e8e", seg); end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL sub_busy got %0d exp 1", busy_cnt); end
        press(4'h0);
        checks++; if ({done, ovf} !== 2'b00) begin errors++; $display("FAIL sub_clr_flags got %b exp 00", {done, ovf}); end
        checks++; if (opnd_idx !== 2'd0) begin errors++; $display("FAIL sub_clr_idx got %0d exp 0", opnd_idx); end
        checks++; if (result !== 8'hFF) begin errors++; $display("FAIL sub_hold got %h exp ff", result); end
    endtask

    task automatic test_logic();
        logic [2:0] v_ms [5] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b110};
        logic [3:0] v_a  [5] = '{4'hC, 4'hC, 4'h5, 4'h3, 4'h9};
        logic [3:0] v_b  [5] = '{4'hA, 4'h3, 4'h3, 4'h9, 4'h3};
        logic [7:0] v_r  [5] = '{8'h08, 8'h0F, 8'h06, 8'h09, 8'h09};
        bit ok;
        for (int i = 0; i < 5; i++) begin
            ms = v_ms[i];
            press(v_a[i]);
            press(v_b[i]);
            wait_done(ok);
            checks++; if (ok !== 1'b1 || result !== v_r[i]) begin errors++; $display("FAIL logic_%0d got done=%b result=%h exp 1/%h", i, done, result, v_r[i]); end
            press(4'h0);
        end
    endtask

    task automatic test_mul();
        bit ok;
        ms = 3'b101; busy_cnt = 0;
        press(4'h7);
        press(4'h9);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mul_done got %b exp 1", done); end
`ifdef SEQ_ALU_MULT_EN
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL mul_busy got %0d exp 4", busy_cnt); end
        checks++; if (result !== 8'h3F) begin errors++; $display("FAIL mul_result got %h exp 3f", result); end
        checks++; if ({err, ovf} !== 2'b00) begin errors++; $display("FAIL mul_flags got %b exp 00", {err, ovf}); end
`else
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL mul_busy got %0d exp 0", busy_cnt); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL mul_result got %h exp 00", result); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mul_err got %b exp 1", err); end
`endif
        press(4'h0);
    endtask

    task automatic test_reserved();
        bit ok;
        ms = 3'b111; busy_cnt = 0;
        press(4'h1);
        press(4'h2);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rsvd_done got %b exp 1", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsvd_err got %b exp 1", err); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rsvd_result got %h exp 00", result); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL rsvd_busy got %0d exp 0", busy_cnt); end
        press(4'h0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rsvd_clr got %b exp 0", err); end
    endtask

    task automatic test_ignore();
        int n = 0;
        ms = 3'b000;
        press(4'h4);
        @(negedge clk);
        din = 4'h5; next_n = 1'b0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b exp 1", busy); end
        next_n = 1'b1; din = 4'hF; ms = 3'b010;
        @(negedge clk);
        next_n = 1'b0;
        repeat (8) @(negedge clk);
        next_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (result !== 8'h09) begin errors++; $display("FAIL ign_result got %h exp 09", result); end
        checks++; if ({done, opnd_idx} !== 3'b000) begin errors++; $display("FAIL ign_return got done=%b idx=%0d exp 0/0", done, opnd_idx); end
    endtask

    task automatic test_abort();
        bit ok;
        int n = 0;
`ifdef SEQ_ALU_MULT_EN
        ms = 3'b101;
`else
        ms = 3'b000;
`endif
        press(4'h7);
        @(negedge clk);
        din = 4'h9; next_n = 1'b0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
        clear = 1'b1;
        #1;
        checks++; if ({busy, done, ovf, err, opnd_idx} !== 6'b0) begin errors++; $display("FAIL abort_flags got %b exp 0", {busy, done, ovf, err, opnd_idx}); end
        checks++; if (result !== 8'h00 || seg !== 16'hC0C0) begin errors++; $display("FAIL abort_result got %h/%h exp 00/c0c0", result, seg); end
        @(negedge clk);
        next_n = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        ms = 3'b000;
        press(4'h1);
        press(4'h1);
        wait_done(ok);
        checks++; if (ok !== 1'b1 || result !== 8'h02) begin errors++; $display("FAIL abort_fresh got done=%b result=%h exp 1/02", done, result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_reserved();
        test_ignore();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
